// File: rtl/uart_rx_frame_checker.sv
// Oversampled UART receiver: 2-flop sync, mid-bit sampling, parity/stop/break checks,
// valid/ready output register with overrun drop, saturating per-error counters.
module uart_rx_frame_checker #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int STOP_BITS  = 1,
  parameter int CNT_W      = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_in,
  input  logic                 baud_tick,
  input  logic [1:0]           parity_type,
  output logic [DATA_BITS-1:0] rx_data,
  output logic [2:0]           error_flag,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 overrun,
  output logic                 busy,
  input  logic                 cnt_clr,
  output logic [CNT_W-1:0]     parity_err_cnt,
  output logic [CNT_W-1:0]     frame_err_cnt,
  output logic [CNT_W-1:0]     overrun_cnt
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [TW-1:0]    HALF_T    = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0]    FULL_T    = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0]    LAST_BIT  = BW'(DATA_BITS - 1);
  localparam logic             LAST_STOP = 1'(STOP_BITS - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_WAIT_HIGH
  } state_t;

  state_t               state_q;
  logic                 sync1_q, sync2_q, prev_q;
  logic [TW-1:0]        tick_q;
  logic [BW-1:0]        bit_q;
  logic                 stop_idx_q;
  logic [DATA_BITS-1:0] shift_q;
  logic                 par_en_q, par_odd_q, par_err_q, par_bit_q;
  logic                 stop_err_q, stop0_q;

  logic [DATA_BITS-1:0] rx_data_q;
  logic [2:0]           error_flag_q;
  logic                 rx_valid_q, overrun_q;
  logic [CNT_W-1:0]     par_cnt_q, frm_cnt_q, ovr_cnt_q;

  logic       rx_s;
  logic       sample;
  logic       frame_done;
  logic       first_stop;
  logic       brk;
  logic       stop_flag;
  logic [2:0] done_flags;
  logic       drop;

  assign rx_s = sync2_q;

  always_comb begin
    sample     = baud_tick && (tick_q == ((state_q == S_START) ? HALF_T : FULL_T));
    frame_done = (state_q == S_STOP) && sample && (stop_idx_q == LAST_STOP);
    first_stop = (stop_idx_q == 1'b0) ? rx_s : stop0_q;
    // Break: every sampled bit of the frame, up to the first stop, was low.
    brk        = ~|shift_q && (!par_en_q || !par_bit_q) && !first_stop;
    stop_flag  = stop_err_q || !rx_s || brk;
    done_flags = {brk, stop_flag, par_en_q && par_err_q};
    drop       = frame_done && rx_valid_q && !rx_ready;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
      prev_q     <= 1'b1;
      tick_q     <= '0;
      bit_q      <= '0;
      stop_idx_q <= 1'b0;
      shift_q    <= '0;
      par_en_q   <= 1'b0;
      par_odd_q  <= 1'b0;
      par_err_q  <= 1'b0;
      par_bit_q  <= 1'b0;
      stop_err_q <= 1'b0;
      stop0_q    <= 1'b1;
    end else begin
      sync1_q <= rx_in;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      if (baud_tick && state_q != S_IDLE && state_q != S_WAIT_HIGH) begin
        tick_q <= sample ? '0 : tick_q + 1'b1;
      end
      case (state_q)
        S_IDLE: begin
          if (prev_q && !rx_s) begin
            state_q    <= S_START;
            tick_q     <= '0;
            bit_q      <= '0;
            stop_idx_q <= 1'b0;
            par_en_q   <= (parity_type == 2'b01) || (parity_type == 2'b10);
            par_odd_q  <= (parity_type == 2'b01);
            par_err_q  <= 1'b0;
            par_bit_q  <= 1'b0;
            stop_err_q <= 1'b0;
          end
        end
        S_START: begin
          if (sample) state_q <= rx_s ? S_IDLE : S_DATA;
        end
        S_DATA: begin
          if (sample) begin
            shift_q <= {rx_s, shift_q[DATA_BITS-1:1]};
            if (bit_q == LAST_BIT) begin
              bit_q   <= '0;
              state_q <= par_en_q ? S_PARITY : S_STOP;
            end else begin
              bit_q <= bit_q + 1'b1;
            end
          end
        end
        S_PARITY: begin
          if (sample) begin
            par_bit_q <= rx_s;
            par_err_q <= rx_s != (par_odd_q ? ~^shift_q : ^shift_q);
            state_q   <= S_STOP;
          end
        end
        S_STOP: begin
          if (sample) begin
            stop_err_q <= stop_err_q || !rx_s;
            if (stop_idx_q == 1'b0) stop0_q <= rx_s;
            if (stop_idx_q == LAST_STOP) begin
              state_q <= stop_flag ? S_WAIT_HIGH : S_IDLE;
            end else begin
              stop_idx_q <= stop_idx_q + 1'b1;
            end
          end
        end
        S_WAIT_HIGH: begin
          if (rx_s) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_data_q    <= '0;
      error_flag_q <= '0;
      rx_valid_q   <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      overrun_q <= drop;
      if (frame_done && !drop) begin
        rx_data_q    <= shift_q;
        error_flag_q <= done_flags;
        rx_valid_q   <= 1'b1;
      end else if (rx_valid_q && rx_ready) begin
        rx_valid_q <= 1'b0;
      end
    end
  end

  // Counters include dropped frames; clear has priority over increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      par_cnt_q <= '0;
      frm_cnt_q <= '0;
      ovr_cnt_q <= '0;
    end else if (cnt_clr) begin
      par_cnt_q <= '0;
      frm_cnt_q <= '0;
      ovr_cnt_q <= '0;
    end else begin
      if (frame_done && done_flags[0] && par_cnt_q != CNT_MAX) par_cnt_q <= par_cnt_q + 1'b1;
      if (frame_done && done_flags[1] && frm_cnt_q != CNT_MAX) frm_cnt_q <= frm_cnt_q + 1'b1;
      if (drop && ovr_cnt_q != CNT_MAX) ovr_cnt_q <= ovr_cnt_q + 1'b1;
    end
  end

  assign rx_data        = rx_data_q;
  assign error_flag     = error_flag_q;
  assign rx_valid       = rx_valid_q;
  assign overrun        = overrun_q;
  assign busy           = (state_q != S_IDLE);
  assign parity_err_cnt = par_cnt_q;
  assign frame_err_cnt  = frm_cnt_q;
  assign overrun_cnt    = ovr_cnt_q;

endmodule
